// File: rtl/frame_packer_pkg.sv
// frame_packer_pkg: shared state encoding and sizing constants for frame_packer.
// The CSUM state exists only when FRAME_PACKER_CHECKSUM_EN is defined.
package frame_packer_pkg;

`ifdef FRAME_PACKER_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;
`endif

    localparam logic [9:0] DEFAULT_HDR_WORD = 10'h3A5;

    // Skid buffer depth and the occupancy at or below which upstream may be asked
    // for another word. One word can be in flight, so the threshold is depth-2.
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RDY_THRESH = 2;

endpackage

// File: rtl/fp_skid_fifo.sv
// fp_skid_fifo: 4-entry skid buffer absorbing the one-cycle request/response
// latency of the upstream interface. Exposes occupancy and a drop strobe for
// pushes that arrive while full without a simultaneous pop.
module fp_skid_fifo
    import frame_packer_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic                  clk_out,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  pop,
    output logic [DATA_W-1:0]     rdata,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  empty,
    output logic                  drop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign rdata   = mem[rd_ptr];

    // Pointers and occupancy.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + FIFO_CNT_W'(1);
            else if (!do_push && do_pop) count <= count - FIFO_CNT_W'(1);
        end
    end

    // Storage; reads are gated by occupancy so the array needs no reset.
    always_ff @(posedge clk_out) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/frame_packer.sv
// frame_packer: packs an upstream word stream into frames of
// header + FRAME_LEN payload words [+ checksum word].
// Define FRAME_PACKER_CHECKSUM_EN to append the modulo-2^DATA_W payload sum
// as a final checksum word; otherwise eop marks the last payload word.
//
// state   | meaning
// IDLE    | no frame open; header loads as soon as the buffer holds a word
// HEAD    | header sits in the output register awaiting transfer
// PAYLOAD | one buffered word loads per free output slot
// CSUM    | checksum word waits for a free output slot (checksum build only)
module frame_packer
    import frame_packer_pkg::*;
#(
    parameter int                DATA_W    = 10,
    parameter int                FRAME_LEN = 16,
    parameter logic [DATA_W-1:0] HDR_WORD  = DATA_W'(DEFAULT_HDR_WORD)
) (
    input  logic              clk_out,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              b_rdy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    input  logic              dout_rdy,
    output logic              ovf
);

    localparam int               CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [DATA_W-1:0]     fifo_rdata;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_empty;
    logic                  fifo_drop;
    logic                  fifo_pop;
    logic                  load_ok;
    logic                  ld;
    logic [DATA_W-1:0]     ld_data;
    logic                  ld_sop;
    logic                  ld_eop;
`ifdef FRAME_PACKER_CHECKSUM_EN
    logic [DATA_W-1:0]     sum_q;
    logic [DATA_W-1:0]     sum_d;
`endif

    fp_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .push    (din_vld),
        .wdata   (din),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .drop    (fifo_drop)
    );

    assign b_rdy   = (fifo_count <= FIFO_CNT_W'(RDY_THRESH));
    // The output slot is free when empty or being drained this cycle.
    assign load_ok = !dout_vld || dout_rdy;

    // Next-state, output-register load selection and buffer pop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        ld       = 1'b0;
        ld_data  = '0;
        ld_sop   = 1'b0;
        ld_eop   = 1'b0;
`ifdef FRAME_PACKER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && load_ok) begin
                    ld      = 1'b1;
                    ld_data = HDR_WORD;
                    ld_sop  = 1'b1;
                    cnt_d   = '0;
`ifdef FRAME_PACKER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD, ST_PAYLOAD: begin
                // In HEAD a free slot means the header is leaving this cycle.
                if (state_q == ST_HEAD && load_ok) state_d = ST_PAYLOAD;
                if (load_ok && !fifo_empty) begin
                    ld       = 1'b1;
                    fifo_pop = 1'b1;
                    ld_data  = fifo_rdata;
`ifdef FRAME_PACKER_CHECKSUM_EN
                    sum_d    = sum_q + fifo_rdata;
`endif
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
`ifdef FRAME_PACKER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        ld_eop  = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef FRAME_PACKER_CHECKSUM_EN
            ST_CSUM: begin
                if (load_ok) begin
                    ld      = 1'b1;
                    ld_data = sum_q;
                    ld_eop  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and payload index registers.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FRAME_PACKER_CHECKSUM_EN
    // Running payload sum, cleared whenever a header is loaded.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end
`endif

    // Output register: loads into a free slot, otherwise holds until accepted.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else if (ld) begin
            dout     <= ld_data;
            dout_vld <= 1'b1;
            dout_sop <= ld_sop;
            dout_eop <= ld_eop;
        end else if (dout_rdy) begin
            dout_vld <= 1'b0;
        end
    end

    // Sticky overflow: set by any word the buffer had to drop.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n)         ovf <= 1'b0;
        else if (fifo_drop) ovf <= 1'b1;
    end

endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: table-driven frames checked by an output scoreboard, plus
// hand-written stall, overflow and mid-frame reset sequences.
module tb_frame_packer;

    localparam int              DATA_W    = 10;
    localparam int              FRAME_LEN = 16;
    localparam logic [9:0]      HDR       = 10'h3A5;
`ifdef FRAME_PACKER_CHECKSUM_EN
    localparam bit              CSUM_ON   = 1'b1;
`else
    localparam bit              CSUM_ON   = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    typedef struct {
        logic [9:0] start;
        logic [9:0] step;
        int         mode;
        logic [9:0] csum;
    } vec_t;

    logic        clk_out  = 1'b0;
    logic        rst_n    = 1'b0;
    logic [9:0]  din      = '0;
    logic        din_vld  = 1'b0;
    logic        b_rdy;
    logic [9:0]  dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_rdy = 1'b1;
    logic        ovf;

    exp_t        exp_q[$];
    logic [9:0]  src_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    logic        rdy_man = 1'b1;
    int          inject_req = 0;

    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [9:0]  pd = '0;
    logic        ps = 1'b0;
    logic        pe = 1'b0;
    logic        in_frame = 1'b0;
    int          xfers = 0;
    int          gaps = 0;
    int          t_push = -1;
    int          t_out = -1;

    frame_packer #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .HDR_WORD  (HDR)
    ) u_dut (
        .clk_out  (clk_out),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .b_rdy    (b_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_rdy (dout_rdy),
        .ovf      (ovf)
    );

    always #5 clk_out = ~clk_out;

    always @(posedge clk_out) cyc <= cyc + 1;

    // Upstream: answers each b_rdy=1 cycle with one word on the following cycle.
    initial begin : upstream
        logic rq;
        int   inject_done;
        inject_done = 0;
        forever begin
            @(negedge clk_out);
            rq = b_rdy;
            @(posedge clk_out);
            #1;
            if (inject_req != inject_done) begin
                din         = 10'h155;
                din_vld     = 1'b1;
                inject_done = inject_req;
            end else if (rq && src_q.size() > 0) begin
                din     = src_q.pop_front();
                din_vld = 1'b1;
            end else begin
                din_vld = 1'b0;
            end
        end
    end

    // Downstream ready pattern: 0 always, 1 random, 2 alternating, 3 manual.
    initial begin : downstream
        forever begin
            @(posedge clk_out);
            #1;
            case (rdy_mode)
                0:       dout_rdy = 1'b1;
                1:       dout_rdy = 1'($urandom_range(0, 1));
                2:       dout_rdy = ~dout_rdy;
                default: dout_rdy = rdy_man;
            endcase
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int val);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected completion", name, val);
    endtask

    // One cycle: hold check, scoreboard compare on transfer, frame bookkeeping.
    task automatic tick();
        exp_t e;
        @(negedge clk_out);
        if (!rst_n) begin
            pv       = 1'b0;
            in_frame = 1'b0;
        end else begin
            if (pv && !pr)
                chk("hold", 32'({dout_vld, dout, dout_sop, dout_eop}), 32'({1'b1, pd, ps, pe}));
            if (din_vld && t_push < 0) t_push = cyc;
            if (dout_vld && t_out < 0) t_out = cyc;
            if (dout_vld && dout_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_word", 32'({dout, dout_sop, dout_eop}), 32'({e.data, e.sop, e.eop}));
                end
                if (dout_sop) begin
                    in_frame = 1'b1;
                    xfers    = 0;
                end
                xfers++;
                if (dout_eop) in_frame = 1'b0;
            end else if (in_frame && !dout_vld) begin
                gaps++;
            end
            pv = dout_vld;
            pr = dout_rdy;
            pd = dout;
            ps = dout_sop;
            pe = dout_eop;
        end
    endtask

    task automatic send_frame(input logic [9:0] start, input logic [9:0] step, input logic [9:0] csum);
        logic [9:0] w;
        exp_q.push_back('{data: HDR, sop: 1'b1, eop: 1'b0});
        for (int i = 0; i < FRAME_LEN; i++) begin
            w = start + step * 10'(i);
            src_q.push_back(w);
            exp_q.push_back('{data: w, sop: 1'b0, eop: (i == FRAME_LEN - 1) && !CSUM_ON});
        end
        if (CSUM_ON) exp_q.push_back('{data: csum, sop: 1'b0, eop: 1'b1});
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0 || src_q.size() != 0) begin
            fail_now("drain_timeout", exp_q.size());
            exp_q.delete();
            src_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int k;
        k = 0;
        while (!(in_frame && xfers >= n) && k < budget) begin
            tick();
            k++;
        end
        if (!(in_frame && xfers >= n)) fail_now("xfer_timeout", xfers);
    endtask

    initial begin : main
        vec_t tbl[5];
        int   occ;
        int   peak;
        int   fall_occ;

        tbl[0] = '{start: 10'h001, step: 10'h001, mode: 0, csum: 10'h088};
        tbl[1] = '{start: 10'h3FF, step: 10'h000, mode: 0, csum: 10'h3F0};
        tbl[2] = '{start: 10'h200, step: 10'h040, mode: 1, csum: 10'h200};
        tbl[3] = '{start: 10'h155, step: 10'h000, mode: 2, csum: 10'h150};
        tbl[4] = '{start: 10'h3F0, step: 10'h001, mode: 1, csum: 10'h378};

        repeat (3) tick();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_vld_sop_eop", 32'({dout_vld, dout_sop, dout_eop}), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("b_rdy_after_release", 32'(b_rdy), 32'h1);
        chk("vld_after_release", 32'(dout_vld), 32'h0);

        for (int r = 0; r < 5; r++) begin
            rdy_mode = tbl[r].mode;
            gaps     = 0;
            t_push   = -1;
            t_out    = -1;
            send_frame(tbl[r].start, tbl[r].step, tbl[r].csum);
            wait_drain(1000);
            if (r == 0) chk("first_header_latency", 32'(t_out - t_push), 32'd2);
            if (tbl[r].mode == 0) chk("no_bubbles", 32'(gaps), 32'h0);
            chk("ovf_clear", 32'(ovf), 32'h0);
        end

        // Ten-cycle downstream stall mid-payload.
        rdy_mode = 3;
        rdy_man  = 1'b1;
        send_frame(10'h010, 10'h003, 10'h268);
        wait_xfers(6, 200);
        rdy_man  = 1'b0;
        peak     = 0;
        fall_occ = -1;
        repeat (10) begin
            tick();
            occ = int'(u_dut.fifo_count);
            if (occ > peak) peak = occ;
            if (!b_rdy && fall_occ < 0) fall_occ = occ;
            chk("b_rdy_vs_occ", 32'(b_rdy), 32'(occ <= 2));
        end
        chk("stall_peak_occ", 32'(peak), 32'd4);
        chk("b_rdy_fall_occ", 32'(fall_occ), 32'd3);
        chk("stall_ovf", 32'(ovf), 32'h0);
        rdy_man = 1'b1;
        wait_drain(500);

        // Forced word into a full buffer while stalled.
        rdy_man = 1'b1;
        send_frame(10'h100, 10'h001, 10'h078);
        wait_xfers(4, 200);
        rdy_man = 1'b0;
        repeat (10) tick();
        chk("full_before_inject", 32'(u_dut.fifo_count), 32'd4);
        chk("ovf_before_inject", 32'(ovf), 32'h0);
        inject_req++;
        repeat (2) tick();
        chk("ovf_set", 32'(ovf), 32'h1);
        repeat (5) tick();
        chk("ovf_sticky", 32'(ovf), 32'h1);
        rdy_man = 1'b1;
        wait_drain(500);
        chk("ovf_sticky_after_drain", 32'(ovf), 32'h1);

        // Reset after the fifth payload word, then a clean frame.
        rdy_mode = 0;
        send_frame(10'h001, 10'h001, 10'h088);
        wait_xfers(6, 200);
        rst_n = 1'b0;
        src_q.delete();
        exp_q.delete();
        #1;
        chk("midrst_dout", 32'(dout), 32'h0);
        chk("midrst_vld_sop_eop", 32'({dout_vld, dout_sop, dout_eop}), 32'h0);
        chk("midrst_ovf", 32'(ovf), 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_b_rdy", 32'(b_rdy), 32'h1);
        chk("midrst_vld_after", 32'(dout_vld), 32'h0);
        send_frame(10'h005, 10'h002, 10'h140);
        wait_drain(500);
        chk("ovf_after_reset", 32'(ovf), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_packer.md
FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 10, word width.
REQ-002 SHALL have parameter FRAME_LEN, default 16, payload words per frame (2..256).
REQ-003 SHALL have parameter HDR_WORD, default 10'h3A5, header word value.
REQ-004 SHALL have port clk_out  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port din  input  DATA_W  upstream word, valid when din_vld=1.
REQ-007 SHALL have port din_vld  input  1  upstream word valid; arrives exactly one cycle after the b_rdy=1 cycle that requested it.
REQ-008 SHALL have port b_rdy  output  1  request to upstream for one word next cycle.
REQ-009 SHALL have port dout  output  DATA_W  framed output word.
REQ-010 SHALL have port dout_vld  output  1  dout valid.
REQ-011 SHALL have port dout_sop  output  1  first word of frame (header); qualified by dout_vld.
REQ-012 SHALL have port dout_eop  output  1  last word of frame; qualified by dout_vld.
REQ-013 SHALL have port dout_rdy  input  1  downstream accept; transfer = dout_vld & dout_rdy.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-015 SHALL buffer incoming words in a 4-entry skid FIFO; push on din_vld, pop when a payload word is loaded into the output register.
REQ-016 SHALL drive b_rdy=1 iff registered occupancy <= 2 (combinational from the count), so one in-flight word can never overflow.
REQ-017 SHALL, on din_vld with FIFO full and no pop that cycle, drop the word and set ovf=1 until reset; simultaneous push and pop on a full FIFO SHALL NOT overflow.
REQ-018 SHALL implement states IDLE, HEAD, PAYLOAD, CSUM.
REQ-019 IDLE->HEAD when FIFO non-empty; HEAD loads HDR_WORD with dout_sop=1, moves to PAYLOAD on its transfer.
REQ-020 PAYLOAD loads one FIFO word per free output slot; dout_vld=0 while FIFO empty (bubbles allowed, frame never aborted); payload counter 0..FRAME_LEN-1, width $clog2(FRAME_LEN).
REQ-021 After the last payload word transfers, SHALL go to CSUM (checksum enabled) or IDLE (disabled).
REQ-022 CSUM loads the sum of the frame's payload words modulo 2^DATA_W with dout_eop=1, then IDLE; sum accumulator cleared at HEAD.
REQ-023 Output register SHALL hold dout/sop/eop stable while dout_vld=1 and dout_rdy=0; a new word loads when register empty or being transferred (zero-bubble throughput).
REQ-024 Latency: first word pushed at cycle N -> header dout_vld at N+2 earliest.
REQ-025 FRAME_LEN=... counter wrap: counter SHALL reset to 0 at every HEAD, never carry into next frame.

Reset
REQ-026 On rst_n=0: b_rdy=1 after release, dout=0, dout_vld=0, dout_sop=0, dout_eop=0, ovf=0, state IDLE, FIFO empty, counter and sum 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; first output after release SHALL be a header.

Configuration
REQ-028 Macro FRAME_PACKER_CHECKSUM_EN defined: CSUM state and checksum word present, eop on checksum word, frame = FRAME_LEN+2 words.
REQ-029 Macro undefined: no CSUM state or accumulator, eop on last payload word, frame = FRAME_LEN+1 words.

Structure
REQ-030 Package frame_packer_pkg SHALL hold state encoding, default HDR_WORD, FIFO depth constant 4, b_rdy threshold 2.
REQ-031 Sub-module fp_skid_fifo SHALL implement the 4-entry buffer with count output.

Verification
REQ-032 Continuous din 1..16, dout_rdy=1, checksum on -> 3A5(sop), 1..16, 136 mod 1024 = 0x088(eop); no bubbles after header.
REQ-033 Same stream, macro off -> 3A5(sop), 1..16 with eop on 16; 17-word frame.
REQ-034 dout_rdy=0 for 10 cycles mid-payload -> b_rdy falls at occupancy 3, FIFO peaks at 4, ovf=0, dout held stable, no word lost.
REQ-035 Force din_vld=1 with FIFO full and dout_rdy=0 -> ovf=1 and stays 1; other words intact.
REQ-036 Payload 0x3FF x16 -> checksum 0x3F0 (wrap modulo 1024).
REQ-037 rst_n pulse after 5th payload word -> all outputs 0, next frame starts with 3A5(sop), counter restarts.
